// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline stage register with flush, bubble
// insertion and a saturating stall counter.
//
// Build option: define PIPE_STAGE_SKID_EN to add a second (skid) entry. The
// FULL state then exists, in_ready_o comes straight from a flop and occupancy
// can reach 2. Without it the stage holds one entry and in_ready_o is
// out_ready_i || !out_valid_o.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   flush_i      synchronous kill of all held entries
//   in_valid_i   upstream offers an entry
//   in_ready_o   stage accepts an entry this cycle
//   in_data_i    upstream payload   [DATA_W]
//   in_ctrl_i    upstream control   [CTRL_W], all-zero is a NOP
//   out_valid_o  entry presented downstream
//   out_ready_i  downstream accepts
//   out_data_o   presented payload (stale when out_valid_o is low)
//   out_ctrl_o   presented control, zero when out_valid_o is low
//   occupancy_o  entries held (0..2)
//   stall_cnt_o  saturating count of out_valid_o && !out_ready_i cycles
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              accept, deliver;

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q, in_ready_d;

    // Registered ready: no combinational path from out_ready_i.
    assign in_ready_o = in_ready_q;
`else
    assign in_ready_o = out_ready_i || !out_valid_o;
`endif

    assign out_valid_o = (state_q != StEmpty);
    assign out_data_o  = main_data_q;
    assign out_ctrl_o  = out_valid_o ? main_ctrl_q : '0;
    assign stall_cnt_o = stall_q;

    assign accept  = in_valid_i && in_ready_o;
    assign deliver = out_valid_o && out_ready_i;

    always_comb begin
        unique case (state_q)
            StBusy:  occupancy_o = 2'd1;
            StFull:  occupancy_o = 2'd2;
            default: occupancy_o = 2'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
`endif

        if (flush_i) begin
            // Anything accepted this cycle is dropped; a delivery still completes.
            state_d = StEmpty;
`ifdef PIPE_STAGE_SKID_EN
            skid_data_d = '0;
            skid_ctrl_d = '0;
`endif
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d     = StBusy;
                        main_data_d = in_data_i;
                        main_ctrl_d = in_ctrl_i;
                    end
                end
                StBusy: begin
                    if (accept && deliver) begin
                        main_data_d = in_data_i;
                        main_ctrl_d = in_ctrl_i;
                    end else if (deliver) begin
                        state_d = StEmpty;
                    end else if (accept) begin
`ifdef PIPE_STAGE_SKID_EN
                        state_d     = StFull;
                        skid_data_d = in_data_i;
                        skid_ctrl_d = in_ctrl_i;
`endif
                        // Without the skid entry, accept implies deliver here.
                    end
                end
                StFull: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (deliver) begin
                        state_d     = StBusy;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        skid_data_d = '0;
                        skid_ctrl_d = '0;
                    end
`else
                    state_d = StEmpty;
`endif
                end
                default: state_d = StEmpty;
            endcase
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    assign in_ready_d = (state_d != StFull);
`endif

    // Stall counter saturates and is cleared only by reset.
    always_comb begin
        stall_d = stall_q;
        if (out_valid_o && !out_ready_i && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            stall_q     <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            stall_q     <= stall_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
`endif
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the driver pushes each accepted entry
// into a queue, a negedge monitor pops and compares every delivery.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;
    localparam int unsigned NW = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i = '0;
    logic [CW-1:0] in_ctrl_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [DW-1:0] out_data_o;
    logic [CW-1:0] out_ctrl_o;
    logic [1:0]    occupancy_o;
    logic [NW-1:0] stall_cnt_o;

    pipe_stage_reg #(
        .DATA_W (DW),
        .CTRL_W (CW),
        .CNT_W  (NW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_ctrl_i   (in_ctrl_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_ctrl_o  (out_ctrl_o),
        .occupancy_o (occupancy_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        int            stamp;
        bit            lat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every delivery must match the oldest outstanding entry.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    check("unexpected_delivery", 32'(out_data_o), 32'hDEAD_BEEF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", 32'(out_data_o), 32'(e.d));
                    check("out_ctrl", 32'(out_ctrl_o), 32'(e.c));
                    if (e.lat) check("latency", 32'(cyc), 32'(e.stamp));
                end
            end
            if (!out_valid_o) check("bubble_ctrl", 32'(out_ctrl_o), 32'd0);
        end
    end

    // Offer one entry (optionally with flush) until accepted, bounded.
    task automatic push(input logic [DW-1:0] d, input logic [CW-1:0] c, input bit fl);
        int  waited;
        bit  done;
        waited     = 0;
        done       = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_ctrl_i  = c;
        flush_i    = fl;
        while (!done) begin
            @(negedge clk_i);
            if (in_ready_o || fl) begin
                if (in_ready_o && !fl) sb.push_back('{d, c, cyc + 1, lat_chk});
                done = 1'b1;
            end else if (waited > 50) begin
                check("push_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
            waited++;
            @(posedge clk_i);
            #1;
        end
        // Entries not delivered in the flush cycle are gone.
        if (fl) sb.delete();
        in_valid_i = 1'b0;
        flush_i    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic do_reset();
        #2 rst_ni = 1'b0;
        sb.delete();
        #1;
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_out_data", 32'(out_data_o), 32'd0);
        check("rst_out_ctrl", 32'(out_ctrl_o), 32'd0);
        check("rst_occupancy", 32'(occupancy_o), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset from time zero
        do_reset();

        // Streaming 1..8 back-to-back, one cycle latency each
        out_ready_i = 1'b1;
        lat_chk     = 1'b1;
        for (int i = 1; i <= 8; i++) push(DW'(i), CW'(i) | CW'(1), 1'b0);
        idle(3);
        check("stream_drain", 32'(sb.size()), 32'd0);
        check("stream_occ", 32'(occupancy_o), 32'd0);
        lat_chk = 1'b0;

        // Backpressure: 0xA then 0xB with out_ready low
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 16'h000A;
        in_ctrl_i   = 4'hA;
        @(negedge clk_i);
        check("bp_ready_empty", 32'(in_ready_o), 32'd1);
        sb.push_back('{16'h000A, 4'hA, 0, 1'b0});
        @(posedge clk_i);
        #1;
        in_data_i = 16'h000B;
        in_ctrl_i = 4'hB;
        @(negedge clk_i);
        check("bp_occ_busy", 32'(occupancy_o), 32'd1);
`ifdef PIPE_STAGE_SKID_EN
        check("bp_ready_busy", 32'(in_ready_o), 32'd1);
        sb.push_back('{16'h000B, 4'hB, 0, 1'b0});
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check("bp_occ_full", 32'(occupancy_o), 32'd2);
        check("bp_ready_full", 32'(in_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_occ_release", 32'(occupancy_o), 32'd2);
`else
        // Ready drops combinationally while the held entry is stalled
        check("bp_ready_busy", 32'(in_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("bp_occ_hold", 32'(occupancy_o), 32'd1);
        check("bp_ready_hold", 32'(in_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_ready_release", 32'(in_ready_o), 32'd1);
        check("bp_occ_release", 32'(occupancy_o), 32'd1);
        sb.push_back('{16'h000B, 4'hB, 0, 1'b0});
`endif
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        idle(3);
        check("bp_drain", 32'(sb.size()), 32'd0);
        check("bp_occ_end", 32'(occupancy_o), 32'd0);

        // Flush with out_ready low: held 0x5 and incoming 0x6 both die
        out_ready_i = 1'b0;
        push(16'h0005, 4'h5, 1'b0);
        push(16'h0006, 4'h6, 1'b1);
        check("flush_valid", 32'(out_valid_o), 32'd0);
        check("flush_ctrl", 32'(out_ctrl_o), 32'd0);
        check("flush_occ", 32'(occupancy_o), 32'd0);
        out_ready_i = 1'b1;
        idle(3);

        // Flush with delivery: 0x7 completes, 0x8 is dropped
        out_ready_i = 1'b0;
        push(16'h0007, 4'h7, 1'b0);
        out_ready_i = 1'b1;
        push(16'h0008, 4'h8, 1'b1);
        check("flushdlv_valid", 32'(out_valid_o), 32'd0);
        check("flushdlv_occ", 32'(occupancy_o), 32'd0);
        idle(3);

        // Stall counter: count, saturate at 15, survive flush
        do_reset();
        out_ready_i = 1'b0;
        push(16'h0009, 4'h9, 1'b0);
        idle(5);
        check("stall_5", 32'(stall_cnt_o), 32'd5);
        idle(15);
        check("stall_sat", 32'(stall_cnt_o), 32'd15);
        idle(2);
        check("stall_hold", 32'(stall_cnt_o), 32'd15);
        push(16'h0000, 4'h0, 1'b1);
        check("stall_after_flush", 32'(stall_cnt_o), 32'd15);
        check("stall_flush_occ", 32'(occupancy_o), 32'd0);

        // Asynchronous reset mid-transfer
        push(16'h00C3, 4'hC, 1'b0);
        idle(2);
        check("pre_rst_valid", 32'(out_valid_o), 32'd1);
        check("pre_rst_data", 32'(out_data_o), 32'h00C3);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
